// File: rtl/ped_crossing_if.sv
// Signal bundle between the vehicle light controller, push-button and the
// pedestrian crossing controller.
interface ped_crossing_if;
  logic       car_red;
  logic       car_yellow;
  logic       car_green;
  logic       ped_btn;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic [7:0] countdown;
  logic       abort;
  logic       fault;

  modport master (
    output car_red, car_yellow, car_green, ped_btn,
    input  walk, dont_walk, req_pending, countdown, abort, fault
  );

  modport slave (
    input  car_red, car_yellow, car_green, ped_btn,
    output walk, dont_walk, req_pending, countdown, abort, fault
  );
endinterface

// File: rtl/ped_crossing.sv
// Pedestrian signal controller: grants WALK only inside a pure-red vehicle
// phase, then a flashing clearance; aborts on phase change, latches lamp faults.
module ped_crossing #(
  parameter int unsigned WALK_T  = 12,
  parameter int unsigned FLASH_T = 6,
  parameter int unsigned BLINK_T = 2
) (
  input  logic           clk,
  input  logic           rst,
  ped_crossing_if.slave  bus
);

  typedef enum logic [1:0] {STOP, WALK, FLASH, FAULT} state_e;

  localparam logic [7:0] WALK_LD  = 8'(WALK_T);
  localparam logic [7:0] FLASH_LD = 8'(FLASH_T);
  localparam logic [7:0] BLINK_LD = 8'(BLINK_T);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       blink_q, blink_d;
  logic       req_q, req_d;
  logic       abort_q, abort_d;
  logic       fault_q, fault_d;
  logic       walk_q, walk_d;
  logic       dw_q, dw_d;
  logic       s1_q, s2_q, s3_q;
  logic       red_only_q;

  logic red_only, red_rise, illegal, btn_edge;

  assign red_only = bus.car_red & ~bus.car_yellow & ~bus.car_green;
  assign red_rise = red_only & ~red_only_q;
  assign illegal  = (bus.car_green & (bus.car_red | bus.car_yellow)) |
                    ~(bus.car_red | bus.car_yellow | bus.car_green);
  assign btn_edge = s2_q & ~s3_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    req_d   = req_q;
    abort_d = 1'b0;
    fault_d = fault_q;

    if (illegal) begin
      state_d = FAULT;
      cnt_d   = '0;
      req_d   = 1'b0;
      fault_d = 1'b1;
    end else begin
      unique case (state_q)
        STOP: begin
          if (btn_edge) req_d = 1'b1;
          // Only a fresh red edge starts WALK, so a mid-red request waits.
          if (red_rise && (req_q || btn_edge)) begin
            state_d = WALK;
            cnt_d   = WALK_LD;
            req_d   = 1'b0;
          end
        end
        WALK: begin
          if (!red_only) begin
            state_d = STOP;
            cnt_d   = '0;
            abort_d = 1'b1;
          end else if (cnt_q == 8'd1) begin
            state_d = FLASH;
            cnt_d   = FLASH_LD;
            bcnt_d  = BLINK_LD;
            blink_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        FLASH: begin
          if (btn_edge) req_d = 1'b1;
          if (!red_only) begin
            state_d = STOP;
            cnt_d   = '0;
            abort_d = 1'b1;
          end else if (cnt_q == 8'd1) begin
            state_d = STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
            if (bcnt_q == 8'd1) begin
              blink_d = ~blink_q;
              bcnt_d  = BLINK_LD;
            end else begin
              bcnt_d = bcnt_q - 8'd1;
            end
          end
        end
        FAULT: begin
          cnt_d = '0;
          req_d = 1'b0;
        end
        default: state_d = FAULT;
      endcase
    end

    // Lamps are decoded from the next state so they leave the flops glitch-free.
    walk_d = (state_d == WALK);
    dw_d   = (state_d == FLASH) ? blink_d : (state_d != WALK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STOP;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      blink_q    <= 1'b0;
      req_q      <= 1'b0;
      abort_q    <= 1'b0;
      fault_q    <= 1'b0;
      walk_q     <= 1'b0;
      dw_q       <= 1'b1;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      red_only_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      blink_q    <= blink_d;
      req_q      <= req_d;
      abort_q    <= abort_d;
      fault_q    <= fault_d;
      walk_q     <= walk_d;
      dw_q       <= dw_d;
      s1_q       <= bus.ped_btn;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      red_only_q <= red_only;
    end
  end

  assign bus.walk        = walk_q;
  assign bus.dont_walk   = dw_q;
  assign bus.req_pending = req_q;
  assign bus.countdown   = cnt_q;
  assign bus.abort       = abort_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing.sv
// Directed-vector bench for ped_crossing with WALK_T=4, FLASH_T=4, BLINK_T=2.
module tb_ped_crossing;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ped_crossing_if bus ();

  ped_crossing #(
    .WALK_T (4),
    .FLASH_T(4),
    .BLINK_T(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lamps(input logic r, input logic y, input logic g);
    bus.car_red    = r;
    bus.car_yellow = y;
    bus.car_green  = g;
  endtask

  task automatic lamp_chk(input string tag, input int w, input int dw, input int cd);
    check({tag, ".walk"}, int'(bus.walk), w);
    check({tag, ".dont_walk"}, int'(bus.dont_walk), dw);
    check({tag, ".countdown"}, int'(bus.countdown), cd);
  endtask

  // Expected (walk, dont_walk, countdown) for the 8 cycles of a full WALK+FLASH.
  int exp_w  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
  int exp_dw [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
  int exp_cd [8] = '{4, 3, 2, 1, 4, 3, 2, 1};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ped_btn = 1'b0;
    lamps(1'b0, 1'b0, 1'b1);
    #2;

    // Reset
    tick(3);
    lamp_chk("rst", 0, 1, 0);
    check("rst.fault", int'(bus.fault), 0);
    check("rst.req", int'(bus.req_pending), 0);
    rst = 1'b0;
    tick(1);
    lamp_chk("post_rst", 0, 1, 0);
    check("post_rst.abort", int'(bus.abort), 0);

    // Press during green: request latched two edges after first sample
    bus.ped_btn = 1'b1;
    tick(1);
    bus.ped_btn = 1'b0;
    tick(1);
    check("sync.req_early", int'(bus.req_pending), 0);
    tick(1);
    check("sync.req_set", int'(bus.req_pending), 1);
    lamps(1'b0, 1'b1, 1'b0);
    tick(1);
    check("yellow.walk", int'(bus.walk), 0);
    lamps(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      lamp_chk($sformatf("cycle%0d", k), exp_w[k], exp_dw[k], exp_cd[k]);
      if (k == 0) check("walk_entry.req", int'(bus.req_pending), 0);
    end
    tick(1);
    lamp_chk("flash_end", 0, 1, 0);
    check("flash_end.abort", int'(bus.abort), 0);

    // Press mid-red: no WALK until the next red rise
    bus.ped_btn = 1'b1;
    tick(1);
    bus.ped_btn = 1'b0;
    tick(2);
    check("midred.req", int'(bus.req_pending), 1);
    tick(3);
    lamp_chk("midred.stop", 0, 1, 0);
    lamps(1'b0, 1'b0, 1'b1);
    tick(1);
    lamps(1'b0, 1'b1, 1'b0);
    tick(1);
    check("midred.yellow.walk", int'(bus.walk), 0);
    lamps(1'b1, 1'b0, 1'b0);
    tick(1);
    lamp_chk("midred.walk", 1, 0, 4);
    check("midred.req_clr", int'(bus.req_pending), 0);

    // Abort: R+Y at countdown 2
    tick(2);
    check("abort.pre_cd", int'(bus.countdown), 2);
    lamps(1'b1, 1'b1, 1'b0);
    tick(1);
    lamp_chk("abort", 0, 1, 0);
    check("abort.pulse", int'(bus.abort), 1);
    lamps(1'b1, 1'b0, 1'b0);
    tick(1);
    check("abort.one_cycle", int'(bus.abort), 0);
    lamp_chk("abort.after", 0, 1, 0);

    // Request on green, then WALK; a press during WALK is ignored
    lamps(1'b0, 1'b0, 1'b1);
    bus.ped_btn = 1'b1;
    tick(1);
    bus.ped_btn = 1'b0;
    tick(2);
    lamps(1'b0, 1'b1, 1'b0);
    tick(1);
    lamps(1'b1, 1'b0, 1'b0);
    tick(1);
    lamp_chk("w2.walk", 1, 0, 4);
    bus.ped_btn = 1'b1;
    tick(1);
    bus.ped_btn = 1'b0;
    tick(2);
    check("walk_press.req", int'(bus.req_pending), 0);
    check("walk_press.cd", int'(bus.countdown), 1);
    tick(1);
    lamp_chk("w2.flash", 0, 1, 4);

    // Button held 20 cycles from FLASH: one request, served at next red rise
    bus.ped_btn = 1'b1;
    tick(3);
    check("held.req_in_flash", int'(bus.req_pending), 1);
    check("held.cd", int'(bus.countdown), 1);
    tick(17);
    check("held.req_kept", int'(bus.req_pending), 1);
    lamp_chk("held.stop", 0, 1, 0);
    bus.ped_btn = 1'b0;
    tick(3);
    lamps(1'b0, 1'b0, 1'b1);
    tick(1);
    lamps(1'b0, 1'b1, 1'b0);
    tick(1);
    lamps(1'b1, 1'b0, 1'b0);
    tick(1);
    lamp_chk("held.served", 1, 0, 4);
    check("held.req_clr", int'(bus.req_pending), 0);

    // Illegal G+R during WALK -> sticky fault
    tick(1);
    lamps(1'b1, 1'b0, 1'b1);
    tick(1);
    lamp_chk("fault", 0, 1, 0);
    check("fault.flag", int'(bus.fault), 1);
    lamps(1'b1, 1'b0, 1'b0);
    bus.ped_btn = 1'b1;
    tick(1);
    bus.ped_btn = 1'b0;
    tick(4);
    check("fault.sticky", int'(bus.fault), 1);
    check("fault.req", int'(bus.req_pending), 0);
    lamp_chk("fault.legal", 0, 1, 0);

    // All lamps dark is also illegal; reset clears the fault
    rst = 1'b1;
    tick(1);
    check("fault.rst_clr", int'(bus.fault), 0);
    rst = 1'b0;
    lamps(1'b0, 1'b0, 1'b0);
    tick(1);
    check("dark.fault", int'(bus.fault), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
